// File: rtl/key_event_if.sv
// Switch-conditioner signal bundle: raw active-low switches in, clean levels and pulses out.
interface key_event_if #(
  parameter int N_SW = 3
);
  logic [N_SW-1:0] i_sw;
  logic [N_SW-1:0] o_level;
  logic [N_SW-1:0] o_press;
  logic [N_SW-1:0] o_release;
  logic [N_SW-1:0] o_repeat;
  logic [N_SW-1:0] o_long;

  // Whatever drives the raw switches and consumes the events.
  modport master (
    output i_sw,
    input  o_level, o_press, o_release, o_repeat, o_long
  );

  // The conditioner itself.
  modport slave (
    input  i_sw,
    output o_level, o_press, o_release, o_repeat, o_long
  );
endinterface

// File: rtl/key_event.sv
// key_event: synchronises and debounces N_SW active-low push switches, then
// emits press/release pulses and auto-repeat pulses while a switch is held.
// All switch FSMs advance only on the shared sample tick.
module key_event #(
  parameter int N_SW         = 3,
  parameter int TICK_DIV     = 500000,
  parameter int DB_TICKS     = 3,
  parameter int HOLD_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.slave  bus
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CMAX = (DB_TICKS > HOLD_TICKS)
                        ? ((DB_TICKS > REPEAT_TICKS) ? DB_TICKS : REPEAT_TICKS)
                        : ((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DB_PRESS   = 3'd1,
    S_PRESSED    = 3'd2,
    S_REPEAT     = 3'd3,
    S_DB_RELEASE = 3'd4
  } state_t;

  logic [N_SW-1:0] sync1_q, sync1_d;
  logic [N_SW-1:0] sync2_q, sync2_d;
  logic [N_SW-1:0] pr;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;

  state_t          state_q [N_SW];
  state_t          state_d [N_SW];
  logic [CW-1:0]   cnt_q   [N_SW];
  logic [CW-1:0]   cnt_d   [N_SW];

  logic [N_SW-1:0] level_q,   level_d;
  logic [N_SW-1:0] press_q,   press_d;
  logic [N_SW-1:0] release_q, release_d;
  logic [N_SW-1:0] repeat_q,  repeat_d;
  logic [N_SW-1:0] long_q,    long_d;

  // Synchronised switches are inverted so that 1 means pressed.
  assign pr   = ~sync2_q;
  assign tick = (tick_cnt_q == TICK_LAST);

  // Synchroniser shift and free-running tick divider.
  always_comb begin
    sync1_d    = bus.i_sw;
    sync2_d    = sync1_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Per-switch debounce/repeat next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    level_d   = '0;
    long_d    = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (tick) begin
        case (state_q[i])
          S_IDLE: begin
            if (pr[i]) begin
              state_d[i] = S_DB_PRESS;
              cnt_d[i]   = CW'(1);
            end
          end
          S_DB_PRESS: begin
            if (!pr[i]) begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == DB_LAST) begin
              state_d[i] = S_PRESSED;
              cnt_d[i]   = '0;
              press_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          S_PRESSED: begin
            if (!pr[i]) begin
              state_d[i] = S_DB_RELEASE;
              cnt_d[i]   = CW'(1);
            end else if (cnt_q[i] == HOLD_LAST) begin
              state_d[i]  = S_REPEAT;
              cnt_d[i]    = '0;
              repeat_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          S_REPEAT: begin
            if (!pr[i]) begin
              state_d[i] = S_DB_RELEASE;
              cnt_d[i]   = CW'(1);
            end else if (cnt_q[i] == REP_LAST) begin
              cnt_d[i]    = '0;
              repeat_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          S_DB_RELEASE: begin
            // A bounce back to pressed restarts the hold timer without a new press.
            if (pr[i]) begin
              state_d[i] = S_PRESSED;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == DB_LAST) begin
              state_d[i]   = S_IDLE;
              cnt_d[i]     = '0;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      // Levels follow the next state so they change on the same edge as the pulses.
      level_d[i] = (state_d[i] == S_PRESSED) || (state_d[i] == S_REPEAT) ||
                   (state_d[i] == S_DB_RELEASE);
      long_d[i]  = (state_d[i] == S_REPEAT);
    end
  end

  // State, counters and registered outputs; reset clears everything to released/idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      tick_cnt_q <= '0;
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
      long_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      long_q     <= long_d;
    end
  end

  assign bus.o_level   = level_q;
  assign bus.o_press   = press_q;
  assign bus.o_release = release_q;
  assign bus.o_repeat  = repeat_q;
  assign bus.o_long    = long_q;

endmodule

// File: tb/tb_key_event.sv
// Testbench for key_event: directed scenarios plus random switch activity,
// checked per tick against a run-length/hold-time reference model.
`timescale 1ns/1ps
module tb_key_event;

  localparam int N    = 3;
  localparam int TD   = 4;
  localparam int DB   = 3;
  localparam int HOLD = 5;
  localparam int REP  = 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   tk;
  int   rep0_cnt;

  key_event_if #(.N_SW(N)) bus ();

  key_event #(
    .N_SW(N), .TICK_DIV(TD), .DB_TICKS(DB), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; tick edges are the multiples of TD.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rep;
    logic [N-1:0] lng;
  } exp_t;

  exp_t sbq[$];

  // Reference model: accepted level, run of samples disagreeing with it,
  // ticks held since press/last repeat, and whether auto-repeat is active.
  bit m_lvl [N];
  bit m_long[N];
  int m_run [N];
  int m_hold[N];

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d want %0d", nm, $time, act, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lvl[i] = 0; m_long[i] = 0; m_run[i] = 0; m_hold[i] = 0;
    end
    tk = 0;
  endtask

  task automatic model_step(input logic [N-1:0] pr);
    exp_t e;
    tk++;
    e.cyc = tk * TD;
    e.lvl = '0; e.prs = '0; e.rel = '0; e.rep = '0; e.lng = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_lvl[i]) begin
        if (pr[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_lvl[i] = 1; m_run[i] = 0; m_hold[i] = 0; m_long[i] = 0; e.prs[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end else if (!pr[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = 0; m_run[i] = 0; m_long[i] = 0; e.rel[i] = 1'b1;
        end
      end else if (m_run[i] > 0) begin
        m_run[i] = 0; m_hold[i] = 0; m_long[i] = 0;
      end else begin
        m_hold[i]++;
        if ((!m_long[i] && m_hold[i] == HOLD) || (m_long[i] && m_hold[i] == REP)) begin
          m_long[i] = 1; m_hold[i] = 0; e.rep[i] = 1'b1;
        end
      end
      e.lvl[i] = m_lvl[i];
      e.lng[i] = m_lvl[i] && m_long[i] && (m_run[i] == 0);
    end
    sbq.push_back(e);
  endtask

  // One sample period: apply switch pattern, predict, wait to just after the tick edge.
  task automatic do_tick(input logic [N-1:0] sw);
    bus.i_sw = sw;
    model_step(~sw);
    repeat (TD) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input logic [N-1:0] sw, input int n);
    for (int k = 0; k < n; k++) do_tick(sw);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   int'(bus.o_level),   0);
    chk({tag, "_press"},   int'(bus.o_press),   0);
    chk({tag, "_release"}, int'(bus.o_release), 0);
    chk({tag, "_repeat"},  int'(bus.o_repeat),  0);
    chk({tag, "_long"},    int'(bus.o_long),    0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    chk("sb_drained_at_reset", sbq.size(), 0);
    sbq.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: tick-output cycles pop the scoreboard, other cycles must be pulse-free.
  always @(negedge clk) begin
    if (rst_n && cyc != 0) begin
      if (bus.o_repeat[0]) rep0_cnt++;
      if (cyc % TD == 0) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("cycle",   cyc,                 e.cyc);
          chk("level",   int'(bus.o_level),   int'(e.lvl));
          chk("press",   int'(bus.o_press),   int'(e.prs));
          chk("release", int'(bus.o_release), int'(e.rel));
          chk("repeat",  int'(bus.o_repeat),  int'(e.rep));
          chk("long",    int'(bus.o_long),    int'(e.lng));
        end
      end else begin
        chk("offtick_pulses",
            int'({bus.o_press, bus.o_release, bus.o_repeat}), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] cur;
    total    = 0;
    bad      = 0;
    rep0_cnt = 0;
    model_reset();

    // Reset held with every switch pressed: outputs stay cleared.
    rst_n    = 1'b0;
    bus.i_sw = '0;
    repeat (5) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;
    ticks(3'b000, 4);
    ticks(3'b111, 4);

    // Glitch: two low ticks never reach acceptance.
    ticks(3'b110, 2);
    ticks(3'b111, 3);

    // Long hold: press at tick 3, repeats at 8,10,...,20.
    @(negedge clk); #1 rep0_cnt = 0;
    ticks(3'b110, 20);
    @(negedge clk); #1;
    chk("hold_repeat_count", rep0_cnt, 7);

    // One-tick release bounce: hold timing restarts, next repeat 5 ticks after return.
    rep0_cnt = 0;
    ticks(3'b111, 1);
    ticks(3'b110, 5);
    @(negedge clk); #1;
    chk("bounce_no_repeat_yet", rep0_cnt, 0);
    ticks(3'b110, 1);
    @(negedge clk); #1;
    chk("bounce_repeat", rep0_cnt, 1);
    ticks(3'b111, 4);

    // Simultaneous presses on sw0 and sw2.
    ticks(3'b010, 5);
    ticks(3'b111, 4);

    // Reset while in auto-repeat, switch still held afterwards.
    ticks(3'b110, 12);
    chk("pre_reset_long", int'(bus.o_long[0]), 1);
    do_reset();
    ticks(3'b110, 4);
    ticks(3'b111, 4);

    // Random independent switch activity.
    cur = '1;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 6) == 0) cur[i] = ~cur[i];
      do_tick(cur);
    end
    ticks(3'b111, 4);

    @(negedge clk); #1;
    chk("sb_empty_at_end", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
